// File: rtl/decode_pipe_stage.sv
// Y86-64 decode/write-back stage: register-ID selection, register file, full operand forwarding, D->E register.
// Latency: one cycle from decode inputs to E outputs; dbg_val is combinational. Stall holds E; bubble (wins) loads a nop.
module decode_pipe_stage #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int RNONE    = 15,
  parameter int RSP_ID   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  localparam logic [3:0] RN  = 4'(RNONE);
  localparam logic [3:0] RSP = 4'(RSP_ID);

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } ereg_t;

  localparam ereg_t NOP = '{icode: 4'h1, ifun: 4'h0, valC: '0, valA: '0, valB: '0,
                            dstE: RN, dstM: RN, srcA: RN, srcB: RN};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  ereg_t             e_q, e_d;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;

  always_comb begin
    src_a = RN;
    src_b = RN;
    dst_e = RN;
    dst_m = RN;
    case (D_icode)
      4'h2:    begin src_a = D_rA; dst_e = D_rB; end
      4'h3:    dst_e = D_rB;
      4'h4:    begin src_a = D_rA; src_b = D_rB; end
      4'h5:    begin src_b = D_rB; dst_m = D_rA; end
      4'h6:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      4'h8:    begin src_b = RSP; dst_e = RSP; end
      4'h9:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      4'hA:    begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
      4'hB:    begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
      default: ;
    endcase
  end

  // IDs outside 0..NUM_REGS-1 (including RNONE) simply match no entry.
  always_comb begin
    rf_a    = '0;
    rf_b    = '0;
    dbg_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_a == 4'(i) && src_a != RN)     rf_a    = regs_q[i];
      if (src_b == 4'(i) && src_b != RN)     rf_b    = regs_q[i];
      if (dbg_sel == 4'(i) && dbg_sel != RN) dbg_val = regs_q[i];
    end
  end

  always_comb begin
    val_a = '0;
    if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    else if (src_a == RN)                   val_a = '0;
    else if (src_a == e_dstE)               val_a = e_valE;
    else if (src_a == M_dstM)               val_a = m_valM;
    else if (src_a == M_dstE)               val_a = M_valE;
    else if (src_a == W_dstM)               val_a = W_valM;
    else if (src_a == W_dstE)               val_a = W_valE;
    else                                    val_a = rf_a;
  end

  always_comb begin
    val_b = '0;
    if (src_b == RN)          val_b = '0;
    else if (src_b == e_dstE) val_b = e_valE;
    else if (src_b == M_dstM) val_b = m_valM;
    else if (src_b == M_dstE) val_b = M_valE;
    else if (src_b == W_dstM) val_b = W_valM;
    else if (src_b == W_dstE) val_b = W_valE;
    else                      val_b = rf_b;
  end

  always_comb begin
    e_d = e_q;
    if (E_bubble)
      e_d = NOP;
    else if (!E_stall)
      e_d = '{icode: D_icode, ifun: D_ifun, valC: D_valC, valA: val_a, valB: val_b,
              dstE: dst_e, dstM: dst_m, srcA: src_a, srcB: src_b};
  end

  // valM is written after valE so it wins when both target the same register (popq %rsp).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      e_q <= NOP;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (W_dstE == 4'(i) && W_dstE != RN) regs_q[i] <= W_valE;
        if (W_dstM == 4'(i) && W_dstM != RN) regs_q[i] <= W_valM;
      end
      e_q <= e_d;
    end
  end

  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed vector table for decode_pipe_stage plus hand-written reset sequences.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_stall, E_bubble;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_pipe_stage dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
    .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA),
    .E_srcB(E_srcB), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  typedef struct {
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [3:0]  e_dE, M_dE, M_dM, W_dE, W_dM;
    logic [63:0] e_vE, M_vE, m_vM, W_vE, W_vM;
    logic        stall, bubble;
    logic [3:0]  dsel;
    logic [3:0]  x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
    logic [63:0] x_valC, x_valA, x_valB, x_dbg;
  } vec_t;

  vec_t tv[$];

  // Idle inputs with the nop expectation; each vector overrides what it exercises.
  function automatic vec_t blank();
    vec_t v;
    v.icode = 4'h1; v.ifun = 4'h0; v.rA = 4'hF; v.rB = 4'hF; v.valC = '0; v.valP = '0;
    v.e_dE = 4'hF; v.M_dE = 4'hF; v.M_dM = 4'hF; v.W_dE = 4'hF; v.W_dM = 4'hF;
    v.e_vE = '0; v.M_vE = '0; v.m_vM = '0; v.W_vE = '0; v.W_vM = '0;
    v.stall = 1'b0; v.bubble = 1'b0; v.dsel = 4'hF;
    v.x_icode = 4'h1; v.x_ifun = 4'h0; v.x_dstE = 4'hF; v.x_dstM = 4'hF;
    v.x_srcA = 4'hF; v.x_srcB = 4'hF; v.x_valC = '0; v.x_valA = '0; v.x_valB = '0; v.x_dbg = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    D_icode = v.icode; D_ifun = v.ifun; D_rA = v.rA; D_rB = v.rB;
    D_valC = v.valC; D_valP = v.valP;
    e_dstE = v.e_dE; e_valE = v.e_vE; M_dstE = v.M_dE; M_valE = v.M_vE;
    M_dstM = v.M_dM; m_valM = v.m_vM; W_dstE = v.W_dE; W_valE = v.W_vE;
    W_dstM = v.W_dM; W_valM = v.W_vM;
    E_stall = v.stall; E_bubble = v.bubble; dbg_sel = v.dsel;
  endtask

  task automatic check_e(input string tag, input vec_t v);
    check({tag, ".icode"}, 64'(E_icode), 64'(v.x_icode));
    check({tag, ".ifun"},  64'(E_ifun),  64'(v.x_ifun));
    check({tag, ".valC"},  E_valC, v.x_valC);
    check({tag, ".valA"},  E_valA, v.x_valA);
    check({tag, ".valB"},  E_valB, v.x_valB);
    check({tag, ".dstE"},  64'(E_dstE), 64'(v.x_dstE));
    check({tag, ".dstM"},  64'(E_dstM), 64'(v.x_dstM));
    check({tag, ".srcA"},  64'(E_srcA), 64'(v.x_srcA));
    check({tag, ".srcB"},  64'(E_srcB), 64'(v.x_srcB));
  endtask

  initial begin
    vec_t v;
    vec_t nop;
    nop = blank();

    // 0: write-back r3=0x10 while a nop decodes
    v = blank(); v.W_dE = 4'h3; v.W_vE = 64'h10; v.dsel = 4'h3; v.x_dbg = 64'h10; tv.push_back(v);
    // 1: OPq r3,r3 reads the just-written register
    v = blank(); v.icode = 4'h6; v.rA = 4'h3; v.rB = 4'h3; v.dsel = 4'h3;
    v.x_icode = 4'h6; v.x_srcA = 4'h3; v.x_srcB = 4'h3; v.x_dstE = 4'h3;
    v.x_valA = 64'h10; v.x_valB = 64'h10; v.x_dbg = 64'h10; tv.push_back(v);
    // 2: read-during-write of r5 through W forwarding
    v = blank(); v.icode = 4'h6; v.ifun = 4'h2; v.rA = 4'h5; v.rB = 4'h1; v.W_dE = 4'h5; v.W_vE = 64'h77;
    v.dsel = 4'h5; v.x_icode = 4'h6; v.x_ifun = 4'h2; v.x_srcA = 4'h5; v.x_srcB = 4'h1; v.x_dstE = 4'h1;
    v.x_valA = 64'h77; v.x_valB = 64'h0; v.x_dbg = 64'h77; tv.push_back(v);
    // 3..5: forwarding priority e > M.dstM > W.dstE
    v = blank(); v.icode = 4'h2; v.rA = 4'h2; v.rB = 4'h6;
    v.e_dE = 4'h2; v.e_vE = 64'hAA; v.M_dM = 4'h2; v.m_vM = 64'hBB; v.W_dE = 4'h2; v.W_vE = 64'hCC;
    v.dsel = 4'h2; v.x_icode = 4'h2; v.x_srcA = 4'h2; v.x_dstE = 4'h6; v.x_valA = 64'hAA; v.x_dbg = 64'hCC;
    tv.push_back(v);
    v.e_dE = 4'hF; v.x_valA = 64'hBB; tv.push_back(v);
    v.M_dM = 4'hF; v.x_valA = 64'hCC; tv.push_back(v);
    // 6: rmmovq, M.dstE for A and W.dstM for B
    v = blank(); v.icode = 4'h4; v.rA = 4'h7; v.rB = 4'h8; v.M_dE = 4'h7; v.M_vE = 64'h11;
    v.W_dM = 4'h8; v.W_vM = 64'h22; v.dsel = 4'h8; v.x_icode = 4'h4; v.x_srcA = 4'h7; v.x_srcB = 4'h8;
    v.x_valA = 64'h11; v.x_valB = 64'h22; v.x_dbg = 64'h22; tv.push_back(v);
    // 7: popq %rsp decode
    v = blank(); v.icode = 4'hB; v.rA = 4'h4; v.x_icode = 4'hB;
    v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_dstM = 4'h4; tv.push_back(v);
    // 8: popq %rsp write-back, valM wins
    v = blank(); v.W_dE = 4'h4; v.W_vE = 64'h100; v.W_dM = 4'h4; v.W_vM = 64'h55;
    v.dsel = 4'h4; v.x_dbg = 64'h55; tv.push_back(v);
    // 9: call, valP into A, rsp forwarded from execute
    v = blank(); v.icode = 4'h8; v.valP = 64'h40; v.valC = 64'h300; v.e_dE = 4'h4; v.e_vE = 64'h1234;
    v.x_icode = 4'h8; v.x_valC = 64'h300; v.x_srcB = 4'h4; v.x_dstE = 4'h4;
    v.x_valA = 64'h40; v.x_valB = 64'h1234; tv.push_back(v);
    // 10: jXX passes valP and ifun
    v = blank(); v.icode = 4'h7; v.ifun = 4'h3; v.valP = 64'h80; v.valC = 64'h99;
    v.x_icode = 4'h7; v.x_ifun = 4'h3; v.x_valC = 64'h99; v.x_valA = 64'h80; tv.push_back(v);
    // 11: RNONE sources must not match forwarders that are also RNONE
    v = blank(); v.icode = 4'h6; v.e_vE = 64'hDEAD; v.m_vM = 64'hBEEF; v.W_vE = 64'hCAFE;
    v.x_icode = 4'h6; tv.push_back(v);
    // 12: unknown icode
    v = blank(); v.icode = 4'hC; v.ifun = 4'h5; v.rA = 4'h1; v.rB = 4'h2; v.valC = 64'h5;
    v.x_icode = 4'hC; v.x_ifun = 4'h5; v.x_valC = 64'h5; tv.push_back(v);
    // 13..14: writes to ID F change nothing
    v = blank(); v.W_dE = 4'hF; v.W_vE = 64'hFFFF; v.W_dM = 4'hF; v.W_vM = 64'hEEEE;
    v.dsel = 4'hF; v.x_dbg = 64'h0; tv.push_back(v);
    v.dsel = 4'h3; v.x_dbg = 64'h10; tv.push_back(v);
    // 15: mrmovq
    v = blank(); v.icode = 4'h5; v.rA = 4'h9; v.rB = 4'h3; v.dsel = 4'h2; v.x_dbg = 64'hCC;
    v.x_icode = 4'h5; v.x_srcB = 4'h3; v.x_dstM = 4'h9; v.x_valB = 64'h10; tv.push_back(v);
    // 16: pushq r8
    v = blank(); v.icode = 4'hA; v.rA = 4'h8; v.x_icode = 4'hA; v.x_srcA = 4'h8; v.x_srcB = 4'h4;
    v.x_dstE = 4'h4; v.x_valA = 64'h22; v.x_valB = 64'h55; tv.push_back(v);
    // 17: irmovq to r10, with r14 written via dstM
    v = blank(); v.icode = 4'h3; v.rB = 4'hA; v.valC = 64'h3; v.W_dM = 4'hE; v.W_vM = 64'h0E0E;
    v.dsel = 4'hE; v.x_dbg = 64'h0E0E; v.x_icode = 4'h3; v.x_valC = 64'h3; v.x_dstE = 4'hA; tv.push_back(v);
    // 18: ret
    v = blank(); v.icode = 4'h9; v.x_icode = 4'h9; v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4;
    v.x_valA = 64'h55; v.x_valB = 64'h55; tv.push_back(v);
    // 19: stall holds ret across a new decode
    v = tv[18]; v.icode = 4'h6; v.rA = 4'h1; v.rB = 4'h2; v.stall = 1'b1; tv.push_back(v);
    // 20: bubble beats stall
    v = nop; v.icode = 4'h6; v.rA = 4'h1; v.rB = 4'h2; v.stall = 1'b1; v.bubble = 1'b1; tv.push_back(v);

    reset = 1'b1;
    drive(nop);
    #1;
    check_e("reset_init", nop);
    check("reset_init.dbg3", dbg_val, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      check_e($sformatf("v%0d", i), tv[i]);
      check($sformatf("v%0d.dbg", i), dbg_val, tv[i].x_dbg);
    end

    // Asynchronous reset between edges, then confirm every register reads 0.
    @(negedge clk);
    v = tv[16];
    drive(v);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_e("async_reset", nop);
    for (int id = 0; id < 16; id++) begin
      dbg_sel = 4'(id);
      #0.1;
      check($sformatf("async_reset.dbg%0d", id), dbg_val, 64'h0);
    end

    // Writes are suppressed while reset stays high across an edge.
    @(negedge clk);
    v = blank(); v.W_dE = 4'h3; v.W_vE = 64'h99; v.dsel = 4'h3;
    drive(v);
    @(posedge clk);
    #1;
    check("reset_nowrite.dbg3", dbg_val, 64'h0);
    check_e("reset_hold", nop);

    // First update after release happens on the next edge, reading cleared registers.
    @(negedge clk);
    reset = 1'b0;
    v = blank(); v.icode = 4'h6; v.rA = 4'h3; v.rB = 4'h8;
    v.x_icode = 4'h6; v.x_srcA = 4'h3; v.x_srcB = 4'h8; v.x_dstE = 4'h8;
    drive(v);
    #1;
    check_e("post_release_pre_edge", nop);
    @(posedge clk);
    #1;
    check_e("post_release", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
